// File: rtl/input_arguments.sv
// input_arguments - parses "+MODE=n +FILE=name" argument strings into a trace handle and mode word.
// Build option: INPUT_ARGUMENTS_DEFAULT_FILE_EN makes a missing FILE token fall back to HANDLE_BASE.
module input_arguments #(
  parameter logic [31:0] HANDLE_BASE = 32'h8000_0003,
  parameter int          MAX_NAME    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        done,
  output logic [31:0] file,
  output logic [31:0] MODE,
  output logic        error
);

  localparam int LW = $clog2(MAX_NAME + 2);
  localparam logic [LW-1:0] LEN_SAT = LW'(MAX_NAME + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KEY   = 3'd1;
  localparam logic [2:0] S_VMODE = 3'd2;
  localparam logic [2:0] S_VFILE = 3'd3;
  localparam logic [2:0] S_SKIP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [31:0]   key_q, key_d;
  logic [2:0]    key_cnt_q, key_cnt_d;
  logic [31:0]   acc_q, acc_d;
  logic          digits_q, digits_d;
  logic [31:0]   mode_val_q, mode_val_d;
  logic [LW-1:0] name_len_q, name_len_d;
  logic          name_ok_q, name_ok_d;
  logic          file_seen_q, file_seen_d;
  logic          done_q, done_d;
  logic [31:0]   file_q, file_d;
  logic [31:0]   mode_q, mode_d;
  logic          error_q, error_d;
  logic          is_space, is_digit, name_len_ok;

  assign is_space    = (in_data == 8'h20);
  assign is_digit    = (in_data >= 8'h30) && (in_data <= 8'h39);

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_cnt_d   = key_cnt_q;
    acc_d       = acc_q;
    digits_d    = digits_q;
    mode_val_d  = mode_val_q;
    name_len_d  = name_len_q;
    name_ok_d   = name_ok_q;
    file_seen_d = file_seen_q;
    done_d      = done_q;
    file_d      = file_q;
    mode_d      = mode_q;
    error_d     = error_q;
    name_len_ok = 1'b0;

    if (in_valid && (state_q != S_DONE)) begin
      case (state_q)
        S_IDLE: begin
          if (in_data == 8'h2B) begin
            state_d   = S_KEY;
            key_d     = 32'd0;
            key_cnt_d = 3'd0;
          end else if (!is_space) begin
            error_d = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_KEY: begin
          if (in_data == 8'h3D) begin
            if (key_cnt_q == 3'd4 && key_q == "MODE") begin
              state_d  = S_VMODE;
              acc_d    = 32'd0;
              digits_d = 1'b0;
            end else if (key_cnt_q == 3'd4 && key_q == "FILE") begin
              state_d    = S_VFILE;
              name_len_d = '0;
            end else begin
              state_d = S_SKIP;
            end
          end else if (is_space || key_cnt_q == 3'd4) begin
            state_d = S_SKIP;
          end else begin
            key_d     = {key_q[23:0], in_data};
            key_cnt_d = key_cnt_q + 3'd1;
          end
        end
        S_VMODE: begin
          if (is_digit) begin
            acc_d    = acc_q * 32'd10 + {24'd0, in_data - 8'h30};
            digits_d = 1'b1;
          end else if (is_space) begin
            if (digits_q) mode_val_d = acc_q;
            state_d = S_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_VFILE: begin
          if (is_space) begin
            name_len_ok = (name_len_q != '0) && (name_len_q != LEN_SAT);
            name_ok_d   = name_len_ok;
            file_seen_d = 1'b1;
            if (!name_len_ok) error_d = 1'b1;
            state_d = S_IDLE;
          end else if (name_len_q != LEN_SAT) begin
            name_len_d = name_len_q + LW'(1);
          end
        end
        S_SKIP: begin
          if (is_space) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      // The final character behaves as if an extra space followed it.
      if (in_last) begin
        if (state_d == S_VMODE && digits_d) mode_val_d = acc_d;
        if (state_d == S_VFILE) begin
          name_len_ok = (name_len_d != '0) && (name_len_d != LEN_SAT);
          name_ok_d   = name_len_ok;
          file_seen_d = 1'b1;
          if (!name_len_ok) error_d = 1'b1;
        end
        state_d = S_DONE;
        done_d  = 1'b1;
        mode_d  = mode_val_d;
`ifdef INPUT_ARGUMENTS_DEFAULT_FILE_EN
        file_d  = (name_ok_d || !file_seen_d) ? HANDLE_BASE : 32'd0;
`else
        file_d  = name_ok_d ? HANDLE_BASE : 32'd0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      key_q       <= 32'd0;
      key_cnt_q   <= 3'd0;
      acc_q       <= 32'd0;
      digits_q    <= 1'b0;
      mode_val_q  <= 32'd0;
      name_len_q  <= '0;
      name_ok_q   <= 1'b0;
      file_seen_q <= 1'b0;
      done_q      <= 1'b0;
      file_q      <= 32'd0;
      mode_q      <= 32'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_cnt_q   <= key_cnt_d;
      acc_q       <= acc_d;
      digits_q    <= digits_d;
      mode_val_q  <= mode_val_d;
      name_len_q  <= name_len_d;
      name_ok_q   <= name_ok_d;
      file_seen_q <= file_seen_d;
      done_q      <= done_d;
      file_q      <= file_d;
      mode_q      <= mode_d;
      error_q     <= error_d;
    end
  end

  assign in_ready = (state_q != S_DONE);
  assign done     = done_q;
  assign file     = file_q;
  assign MODE     = mode_q;
  assign error    = error_q;

endmodule

// File: tb/tb_input_arguments.sv
// tb_input_arguments - directed and random argument strings checked against a token-level model.
module tb_input_arguments;

  localparam logic [31:0] BASE = 32'h8000_0003;
  localparam int MAXN = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        done;
  logic [31:0] file_o;
  logic [31:0] mode_o;
  logic        error_o;

  int n_assert = 0;
  int n_fail = 0;

  input_arguments #(.HANDLE_BASE(BASE), .MAX_NAME(MAXN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .done(done), .file(file_o), .MODE(mode_o), .error(error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Token-level reference: split on spaces, interpret each +KEY=VALUE token.
  task automatic model(input string s, output logic [31:0] f, output logic [31:0] m, output logic e);
    int start, eq, vlen;
    string tok, key, val;
    bit name_ok, seen, all_dig;
    longint acc;
    name_ok = 0; seen = 0; m = 0; e = 0; start = 0;
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == 8'h20) begin
        if (i > start) begin
          tok = s.substr(start, i - 1);
          if (tok[0] != 8'h2B) begin
            e = 1;
          end else begin
            eq = -1;
            for (int j = 1; j < tok.len(); j++) if (eq < 0 && tok[j] == 8'h3D) eq = j;
            if (eq > 0) begin
              key  = (eq > 1) ? tok.substr(1, eq - 1) : "";
              vlen = tok.len() - eq - 1;
              val  = (vlen > 0) ? tok.substr(eq + 1, tok.len() - 1) : "";
              if (key == "MODE" && vlen > 0) begin
                all_dig = 1; acc = 0;
                for (int j = 0; j < vlen; j++) begin
                  if (val[j] < 8'h30 || val[j] > 8'h39) all_dig = 0;
                  else acc = acc * 10 + longint'(val[j] - 8'h30);
                end
                if (all_dig) m = acc[31:0];
                else e = 1;
              end else if (key == "FILE") begin
                seen = 1;
                name_ok = (vlen >= 1 && vlen <= MAXN);
                if (!name_ok) e = 1;
              end
            end
          end
        end
        start = i + 1;
      end
    end
`ifdef INPUT_ARGUMENTS_DEFAULT_FILE_EN
    f = (name_ok || !seen) ? BASE : 32'd0;
`else
    f = name_ok ? BASE : 32'd0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic send_str(input string s, input bit with_last);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = with_last && (i == s.len() - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_case(input string tag, input string s);
    logic [31:0] ef, em;
    logic ee;
    model(s, ef, em, ee);
    do_reset();
    send_str(s, 1'b1);
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    check({tag, ".file"}, file_o, ef);
    check({tag, ".mode"}, mode_o, em);
    check({tag, ".error"}, {31'd0, error_o}, {31'd0, ee});
    check({tag, ".ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  function automatic string name_of(input int n);
    string r = "";
    for (int i = 0; i < n; i++) r = $sformatf("%s%c", r, 8'(97 + $urandom_range(0, 25)));
    return r;
  endfunction

  function automatic string digits_of(input int n);
    string r = "";
    for (int i = 0; i < n; i++) r = $sformatf("%s%0d", r, $urandom_range(0, 9));
    return r;
  endfunction

  function automatic string gen_token();
    int k, l;
    k = $urandom_range(0, 6);
    case (k)
      0, 1: return {"+MODE=", digits_of($urandom_range(0, 12))};
      2: return {"+MODE=", digits_of($urandom_range(0, 3)), "x"};
      3: begin
        l = $urandom_range(0, 5);
        case (l)
          0: return "+FILE=";
          1: return {"+FILE=", name_of(1)};
          2: return {"+FILE=", name_of(MAXN)};
          3: return {"+FILE=", name_of(MAXN + 1)};
          default: return {"+FILE=", name_of($urandom_range(2, 20))};
        endcase
      end
      4: return {"+FOO=", digits_of(2)};
      5: return "junk";
      default: return "+MODEX=5";
    endcase
  endfunction

  string s, tok, long65, long64;
  logic [31:0] ef, em;
  logic ee;

  initial begin
    // Reset state
    rst_n = 1'b0;
    #12;
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.file", file_o, 32'd0);
    check("rst.mode", mode_o, 32'd0);
    check("rst.error", {31'd0, error_o}, 32'd0);
    check("rst.ready", {31'd0, in_ready}, 32'd1);

    // Basic string, done exactly one cycle after the in_last transfer
    do_reset();
    send_str("+MODE=1 +FILE=trace.tx", 1'b0);
    check("basic.pre_done", {31'd0, done}, 32'd0);
    check("basic.pre_file", file_o, 32'd0);
    send_str("t", 1'b1);
    check("basic.done", {31'd0, done}, 32'd1);
    check("basic.file", file_o, 32'h8000_0003);
    check("basic.mode", mode_o, 32'd1);
    check("basic.error", {31'd0, error_o}, 32'd0);

    // Characters after done have no effect
    send_str("+MODE=9 +FILE=", 1'b1);
    check("post.done", {31'd0, done}, 32'd1);
    check("post.file", file_o, 32'h8000_0003);
    check("post.mode", mode_o, 32'd1);
    check("post.error", {31'd0, error_o}, 32'd0);
    check("post.ready", {31'd0, in_ready}, 32'd0);

    // Directed spec cases
    run_case("wrap", "+MODE=4294967297");
    check("wrap.const", mode_o, 32'd1);
    run_case("last_wins", "+MODE=1 +MODE=0");
    check("last_wins.const", mode_o, 32'd0);
    run_case("bad_digit", "+MODE=2x");
    check("bad_digit.const", {31'd0, error_o}, 32'd1);
    run_case("unknown", "+FOO=9   +MODE=3");
`ifdef INPUT_ARGUMENTS_DEFAULT_FILE_EN
    check("unknown.const", file_o, 32'h8000_0003);
`else
    check("unknown.const", file_o, 32'd0);
`endif
    long65 = name_of(65);
    long64 = name_of(64);
    run_case("name65", {"+FILE=", long65});
    check("name65.const", file_o, 32'd0);
    run_case("name64", {"+FILE=", long64});
    check("name64.const", file_o, 32'h8000_0003);
    run_case("file_override", "+FILE=a.txt +FILE=");
    check("file_override.const", file_o, 32'd0);
    run_case("empty_mode", "+MODE=5 +MODE=");
    run_case("leading_junk", "  x +MODE=12");

    // Asynchronous reset mid-string
    do_reset();
    send_str("+MODE=7 x", 1'b0);
    check("mid.error_set", {31'd0, error_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async.error", {31'd0, error_o}, 32'd0);
    check("async.done", {31'd0, done}, 32'd0);
    check("async.file", file_o, 32'd0);
    check("async.mode", mode_o, 32'd0);
    check("async.ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    send_str("+MODE=8", 1'b1);
    check("after_async.mode", mode_o, 32'd8);
    check("after_async.error", {31'd0, error_o}, 32'd0);

    // Randomized strings against the reference model
    for (int n = 0; n < 25; n++) begin
      s = "";
      if ($urandom_range(0, 3) == 0) s = " ";
      for (int t = 0; t < $urandom_range(1, 5); t++) begin
        tok = gen_token();
        if (t > 0) begin
          for (int sp = 0; sp < $urandom_range(1, 3); sp++) s = {s, " "};
        end
        s = {s, tok};
      end
      run_case($sformatf("rand%0d", n), s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
